// File: rtl/scan_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scan_rx_pkg
// Description : Shared types and helpers for the scan_receiver block:
//               scan FSM state encoding, overflow saturation limit and the
//               channel-select width function.
// Revision    : 1.0 - initial release
// ============================================================================
package scan_rx_pkg;

    // Scan FSM states
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Saturation limit of the dropped-sample counter
    localparam logic [7:0] c_OVF_MAX = 8'hFF;

    // Width of the channel-select bus; never narrower than one bit
    function automatic int ch_width(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/scan_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : scan_rx_fifo
// Description : Generic synchronous first-word-fall-through FIFO. The head
//               entry is presented combinationally; while empty the output
//               holds the most recently popped word. Pointers carry one extra
//               wrap bit to tell full from empty.
// Revision    : 1.0 - initial release
// ============================================================================
module scan_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_AW = $clog2(DEPTH);

    logic [c_AW:0]      r_wr_q, w_wr_d;
    logic [c_AW:0]      r_rd_q, w_rd_d;
    logic [WIDTH-1:0]   r_mem_q [DEPTH];
    logic [WIDTH-1:0]   r_hold_q, w_hold_d;
    logic [WIDTH-1:0]   w_head;
    logic               w_do_pop;
    logic               w_do_push;

    assign o_empty   = (r_wr_q == r_rd_q);
    assign o_full    = (r_wr_q[c_AW] != r_rd_q[c_AW]) &&
                       (r_wr_q[c_AW-1:0] == r_rd_q[c_AW-1:0]);
    assign w_head    = r_mem_q[r_rd_q[c_AW-1:0]];
    assign w_do_pop  = i_pop && !o_empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_rdata   = o_empty ? r_hold_q : w_head;

    // Pointer advance and last-popped word capture
    always_comb begin
        w_wr_d   = r_wr_q;
        w_rd_d   = r_rd_q;
        w_hold_d = r_hold_q;
        if (w_do_push) begin
            w_wr_d = r_wr_q + {{c_AW{1'b0}}, 1'b1};
        end
        if (w_do_pop) begin
            w_rd_d   = r_rd_q + {{c_AW{1'b0}}, 1'b1};
            w_hold_d = w_head;
        end
    end

    // Pointer and hold registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_q   <= '0;
            r_rd_q   <= '0;
            r_hold_q <= '0;
        end else begin
            r_wr_q   <= w_wr_d;
            r_rd_q   <= w_rd_d;
            r_hold_q <= w_hold_d;
        end
    end

    // Storage array
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_q[i] <= '0;
            end
        end else if (w_do_push) begin
            r_mem_q[r_wr_q[c_AW-1:0]] <= i_wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/scan_receiver.sv
`default_nettype none
// ============================================================================
// Module      : scan_receiver
// Description : Multi-channel scanning receiver. Steps a channel select
//               across NCH sources, dwells DWELL cycles on each, samples the
//               shared bus in the last dwell cycle and queues (channel, data)
//               records in an FWFT FIFO with valid/ready output. Keeps a
//               per-channel last-value snapshot and a saturating drop count.
//               Optional build macro SCAN_RX_CHANGE_FILTER_EN: only samples
//               that differ from the channel's last value are queued (the
//               first sample of each channel after reset always is).
// Revision    : 1.0 - initial release
// ============================================================================
module scan_receiver
    import scan_rx_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int NCH        = 4,
    parameter int DWELL      = 2,
    parameter int FIFO_DEPTH = 4,
    localparam int c_CH_W    = ch_width(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    output logic [c_CH_W-1:0]    sel,
    input  logic [WIDTH-1:0]     bus_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [c_CH_W-1:0]    out_ch,
    output logic [NCH*WIDTH-1:0] last_data,
    output logic [7:0]           ovf_cnt,
    output logic                 busy
);

    localparam int                c_DW        = $clog2(DWELL);
    localparam logic [c_DW-1:0]   c_DCNT_MAX  = c_DW'(DWELL - 1);
    localparam logic [c_CH_W-1:0] c_SEL_MAX   = c_CH_W'(NCH - 1);

    typedef struct packed {
        logic [c_CH_W-1:0] ch;
        logic [WIDTH-1:0]  data;
    } rec_t;

    state_t             r_state_q, w_state_d;
    logic [c_CH_W-1:0]  r_sel_q,   w_sel_d;
    logic [c_DW-1:0]    r_dcnt_q,  w_dcnt_d;
    logic [WIDTH-1:0]   r_last_q [NCH];
    logic [WIDTH-1:0]   w_last_d [NCH];
    logic [7:0]         r_ovf_q,   w_ovf_d;
    logic               w_sample;
    logic               w_push_req;
    logic               w_push_ok;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    rec_t               w_wrec;
    rec_t               w_head;

    // Scan sequencing: dwell counting, channel stepping and en evaluation
    always_comb begin
        w_state_d = r_state_q;
        w_sel_d   = r_sel_q;
        w_dcnt_d  = r_dcnt_q;
        w_sample  = 1'b0;
        case (r_state_q)
            IDLE: begin
                w_sel_d  = '0;
                w_dcnt_d = '0;
                if (en) begin
                    w_state_d = SCAN;
                end
            end
            SCAN: begin
                if (r_dcnt_q == c_DCNT_MAX) begin
                    // en only matters here; a started dwell always completes
                    w_sample = 1'b1;
                    w_dcnt_d = '0;
                    if (en) begin
                        w_sel_d = (r_sel_q == c_SEL_MAX) ? '0 : r_sel_q + c_CH_W'(1);
                    end else begin
                        w_state_d = IDLE;
                        w_sel_d   = '0;
                    end
                end else begin
                    w_dcnt_d = r_dcnt_q + c_DW'(1);
                end
            end
            default: begin
                w_state_d = IDLE;
                w_sel_d   = '0;
                w_dcnt_d  = '0;
            end
        endcase
    end

    // Scan state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= IDLE;
            r_sel_q   <= '0;
            r_dcnt_q  <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_sel_q   <= w_sel_d;
            r_dcnt_q  <= w_dcnt_d;
        end
    end

`ifdef SCAN_RX_CHANGE_FILTER_EN
    logic [NCH-1:0] r_seen_q, w_seen_d;

    // Remember which channels have produced a sample since reset
    always_comb begin
        w_seen_d = r_seen_q;
        if (w_sample) begin
            w_seen_d[r_sel_q] = 1'b1;
        end
    end

    // Seen-flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seen_q <= '0;
        end else begin
            r_seen_q <= w_seen_d;
        end
    end

    assign w_push_req = w_sample &&
                        (!r_seen_q[r_sel_q] || (bus_data != r_last_q[r_sel_q]));
`else
    assign w_push_req = w_sample;
`endif

    assign w_pop     = out_valid && out_ready;
    assign w_push_ok = w_push_req && (!w_full || w_pop);
    assign w_wrec    = '{ch: r_sel_q, data: bus_data};

    // Snapshot update and dropped-sample accounting
    always_comb begin
        w_last_d = r_last_q;
        w_ovf_d  = r_ovf_q;
        if (w_sample) begin
            w_last_d[r_sel_q] = bus_data;
        end
        if (w_push_req && !w_push_ok && (r_ovf_q != c_OVF_MAX)) begin
            w_ovf_d = r_ovf_q + 8'd1;
        end
    end

    // Snapshot and overflow registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NCH; k++) begin
                r_last_q[k] <= '0;
            end
            r_ovf_q <= '0;
        end else begin
            r_last_q <= w_last_d;
            r_ovf_q  <= w_ovf_d;
        end
    end

    scan_rx_fifo #(
        .WIDTH (c_CH_W + WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push_ok),
        .i_wdata (w_wrec),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    generate
        for (genvar k = 0; k < NCH; k++) begin : g_flat
            assign last_data[k*WIDTH +: WIDTH] = r_last_q[k];
        end
    endgenerate

    assign sel       = r_sel_q;
    assign out_valid = !w_empty;
    assign out_data  = w_head.data;
    assign out_ch    = w_head.ch;
    assign ovf_cnt   = r_ovf_q;
    assign busy      = (r_state_q == SCAN);

endmodule
`default_nettype wire
